// File: rtl/rootvoter_pkg.sv
`default_nettype none
// ==========================================================================
// rootvoter_pkg : shared FSM encoding and reset constants for root voter
// Rev 1.0
// ==========================================================================
package rootvoter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam logic [15:0] c_TIMEOUT_RST = 16'd255;

endpackage
`default_nettype wire

// File: rtl/timeout_counter.sv
`default_nettype none
// ==========================================================================
// timeout_counter : loadable down-counter, expired flags a zero count
// Rev 1.0
// ==========================================================================
module timeout_counter #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              en,
  input  logic [DWIDTH-1:0] din,
  output logic              expired
);

  logic [DWIDTH-1:0] r_cnt;

  // Load wins over decrement so a fresh window always starts at the full value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= din;
    end else if (en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/rootvoter_timeout_ctrl.sv
`default_nettype none
// ==========================================================================
// rootvoter_timeout_ctrl : arms a timeout window on first core result and
// issues one vote request on full arrival or expiry.  Rev 1.0
// ==========================================================================
module rootvoter_timeout_ctrl
  import rootvoter_pkg::*;
#(
  parameter int                NCORES      = 4,
  parameter int                DWIDTH      = 16,
  parameter logic [DWIDTH-1:0] TIMEOUT_RST = DWIDTH'(c_TIMEOUT_RST)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic [DWIDTH-1:0] cfg_timeout,
  input  logic              start,
  input  logic              clear,
  input  logic [NCORES-1:0] core_done,
  output logic              busy,
  output logic              vote_req,
  output logic              timeout_flag,
  output logic [NCORES-1:0] arrived,
  output logic [NCORES-1:0] missing,
  output logic [2:0]        state_o
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NCORES-1:0] r_arrived;
  logic [NCORES-1:0] w_arrived_nxt;
  logic [NCORES-1:0] w_arr_or;
  logic [DWIDTH-1:0] r_cfg;
  logic              r_vote_req;
  logic              w_vote_nxt;
  logic              w_load;
  logic              w_en;
  logic              w_expired;
  logic              w_any;
  logic              w_all;

  assign w_arr_or = r_arrived | core_done;
  assign w_any    = |core_done;
  assign w_all    = &w_arr_or;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cfg <= TIMEOUT_RST;
    end else if (cfg_we) begin
      r_cfg <= cfg_timeout;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_arrived_nxt = r_arrived;
    w_load        = 1'b0;
    if (clear) begin
      w_state_nxt   = IDLE;
      w_arrived_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt   = ARMED;
            w_arrived_nxt = '0;
          end
        end
        ARMED: begin
          if (w_any) begin
            w_arrived_nxt = w_arr_or;
            w_load        = 1'b1;
            w_state_nxt   = w_all ? DONE : WAIT;
          end
        end
        WAIT: begin
          // A last arrival on the expiry edge still counts as complete.
          w_arrived_nxt = w_arr_or;
          if (w_all) begin
            w_state_nxt = DONE;
          end else if (w_expired) begin
            w_state_nxt = TIMEOUT;
          end
        end
        DONE, TIMEOUT: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt   = IDLE;
          w_arrived_nxt = '0;
        end
      endcase
    end
  end

  assign w_en       = (r_state == WAIT) && !w_expired;
  assign w_vote_nxt = ((w_state_nxt == DONE) || (w_state_nxt == TIMEOUT)) &&
                      !((r_state == DONE) || (r_state == TIMEOUT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_arrived  <= '0;
      r_vote_req <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_arrived  <= w_arrived_nxt;
      r_vote_req <= w_vote_nxt;
    end
  end

  timeout_counter #(
    .DWIDTH (DWIDTH)
  ) u_timeout_counter (
    .clk     (clk),
    .rstn    (rstn),
    .load    (w_load),
    .en      (w_en),
    .din     (r_cfg),
    .expired (w_expired)
  );

  assign busy         = (r_state == ARMED) || (r_state == WAIT);
  assign vote_req     = r_vote_req;
  assign timeout_flag = (r_state == TIMEOUT);
  assign arrived      = r_arrived;
  assign missing      = (r_state == TIMEOUT) ? ~r_arrived : '0;
  assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rootvoter_timeout_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_rootvoter_timeout_ctrl : scoreboard bench for the root voter timeout FSM
// Rev 1.0
// ==========================================================================
module tb_rootvoter_timeout_ctrl;

  logic        clk;
  logic        rstn;
  logic        cfg_we;
  logic [15:0] cfg_timeout;
  logic        start;
  logic        clear;
  logic [3:0]  core_done;
  logic        busy;
  logic        vote_req;
  logic        timeout_flag;
  logic [3:0]  arrived;
  logic [3:0]  missing;
  logic [2:0]  state_o;

  typedef struct {
    logic       tflag;
    logic [3:0] arr;
    logic [3:0] miss;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c0;

  rootvoter_timeout_ctrl #(
    .NCORES      (4),
    .DWIDTH      (16),
    .TIMEOUT_RST (16'd255)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_we       (cfg_we),
    .cfg_timeout  (cfg_timeout),
    .start        (start),
    .clear        (clear),
    .core_done    (core_done),
    .busy         (busy),
    .vote_req     (vote_req),
    .timeout_flag (timeout_flag),
    .arrived      (arrived),
    .missing      (missing),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every vote_req pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rstn && vote_req) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL vote_unexpected cyc=%0d state=%0d arrived=%b", cyc, state_o, arrived);
      end else begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL vote_timing actual_cyc=%0d required_cyc=%0d", cyc, e.cyc);
        end
        total++;
        if (timeout_flag !== e.tflag || arrived !== e.arr || missing !== e.miss) begin
          bad++;
          $display("FAIL vote_result actual tflag=%b arr=%b miss=%b required tflag=%b arr=%b miss=%b",
                   timeout_flag, arrived, missing, e.tflag, e.arr, e.miss);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m);
    core_done = m;
    tick();
    core_done = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] v);
    cfg_we      = 1'b1;
    cfg_timeout = v;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic push_exp(input logic tf, input logic [3:0] a, input logic [3:0] m, input int at);
    exp_t e;
    e.tflag = tf;
    e.arr   = a;
    e.miss  = m;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL vote_missing pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rstn        = 1'b0;
    cfg_we      = 1'b0;
    cfg_timeout = '0;
    start       = 1'b0;
    clear       = 1'b0;
    core_done   = '0;
    tick();
    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vote", 32'(vote_req), 32'd0);
    chk("rst_tflag", 32'(timeout_flag), 32'd0);
    chk("rst_arrived", 32'(arrived), 32'd0);
    chk("rst_missing", 32'(missing), 32'd0);
    rstn = 1'b1;
    tick();

    // core_done is ignored while idle
    drive(4'hf);
    chk("idle_ignore_arr", 32'(arrived), 32'd0);
    chk("idle_ignore_state", 32'(state_o), 32'd0);

    // full arrival, T=10, with a repeated pulse from core 0
    set_cfg(16'd10);
    do_start();
    chk("armed_state", 32'(state_o), 32'd1);
    chk("armed_busy", 32'(busy), 32'd1);
    c0 = cyc + 1;
    push_exp(1'b0, 4'hf, 4'h0, c0 + 5);
    drive(4'h1);
    drive(4'h0);
    drive(4'h0);
    drive(4'h6);
    drive(4'h1);
    chk("wait_arr_partial", 32'(arrived), 32'h7);
    drive(4'h8);
    chk("done_state", 32'(state_o), 32'd3);
    chk("done_busy", 32'(busy), 32'd0);
    wait_drain(4);
    do_start();
    chk("done_ignores_start", 32'(state_o), 32'd3);
    drive(4'h0);
    chk("done_vote_low", 32'(vote_req), 32'd0);
    chk("done_arr_frozen", 32'(arrived), 32'hf);
    do_clear();
    chk("clear_state", 32'(state_o), 32'd0);
    chk("clear_arr", 32'(arrived), 32'd0);

    // timeout, T=3
    set_cfg(16'd3);
    do_start();
    c0 = cyc + 1;
    push_exp(1'b1, 4'h3, 4'hc, c0 + 4);
    drive(4'h3);
    wait_drain(10);
    chk("to_state", 32'(state_o), 32'd4);
    chk("to_flag_hold", 32'(timeout_flag), 32'd1);
    chk("to_missing_hold", 32'(missing), 32'hc);
    do_clear();
    chk("to_clear_missing", 32'(missing), 32'd0);

    // last arrival on the expiry edge: DONE wins
    do_start();
    c0 = cyc + 1;
    push_exp(1'b0, 4'hf, 4'h0, c0 + 4);
    drive(4'h7);
    drive(4'h0);
    drive(4'h0);
    drive(4'h0);
    drive(4'h8);
    wait_drain(4);
    chk("coinc_state", 32'(state_o), 32'd3);
    do_clear();

    // all cores at once from ARMED
    do_start();
    c0 = cyc + 1;
    push_exp(1'b0, 4'hf, 4'h0, c0);
    drive(4'hf);
    wait_drain(4);
    chk("all_state", 32'(state_o), 32'd3);
    do_clear();

    // config write mid-window affects only the next round
    set_cfg(16'd5);
    do_start();
    c0 = cyc + 1;
    push_exp(1'b1, 4'h1, 4'he, c0 + 6);
    drive(4'h1);
    drive(4'h0);
    set_cfg(16'd20);
    wait_drain(20);
    do_clear();
    do_start();
    c0 = cyc + 1;
    push_exp(1'b1, 4'h3, 4'hc, c0 + 21);
    drive(4'h3);
    wait_drain(40);
    chk("cfg20_state", 32'(state_o), 32'd4);
    do_clear();

    // clear during WAIT aborts without a vote
    do_start();
    drive(4'h1);
    drive(4'h0);
    chk("abort_wait_state", 32'(state_o), 32'd2);
    do_clear();
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_arr", 32'(arrived), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (30) tick();

    // asynchronous reset during WAIT, then default window is back
    set_cfg(16'd7);
    do_start();
    drive(4'h1);
    drive(4'h0);
    rstn = 1'b0;
    #1;
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_arr", 32'(arrived), 32'd0);
    chk("async_vote", 32'(vote_req), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    do_start();
    c0 = cyc + 1;
    push_exp(1'b1, 4'h1, 4'he, c0 + 256);
    drive(4'h1);
    wait_drain(300);
    do_clear();

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
